// File: rtl/cache_refill_arbiter.sv
// Merges NUM_PORTS cache refill/writeback streams onto one memory port (round-robin),
// routes in-order responses back through a tag FIFO, and aggregates per-cache flush completions.
module cache_refill_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REQ_W           = 77,
    parameter int RESP_W          = 47
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        cache_req_val,
    output logic [NUM_PORTS-1:0]        cache_req_rdy,
    input  logic [NUM_PORTS*REQ_W-1:0]  cache_req_msg,
    output logic [NUM_PORTS-1:0]        cache_resp_val,
    input  logic [NUM_PORTS-1:0]        cache_resp_rdy,
    output logic [NUM_PORTS*RESP_W-1:0] cache_resp_msg,
    output logic                        memreq_val,
    input  logic                        memreq_rdy,
    output logic [REQ_W-1:0]            memreq_msg,
    input  logic                        memresp_val,
    output logic                        memresp_rdy,
    input  logic [RESP_W-1:0]           memresp_msg,
    input  logic                        flush,
    input  logic [NUM_PORTS-1:0]        cache_flush_done,
    output logic                        flush_done,
    output logic [1:0]                  flush_state_o
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {FL_IDLE = 2'd0, FL_WAIT = 2'd1, FL_DONE = 2'd2} flush_state_e;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant;
    logic [IDX_W:0]   cand;
    logic             any_val;
    logic [IDX_W-1:0] tag_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] head;
    logic             full, empty, req_fire, resp_fire;

    flush_state_e         fl_q, fl_d;
    logic [NUM_PORTS-1:0] sticky_q, sticky_d, seen;

    // First valid channel at or after rr_ptr, scanning cyclically.
    always_comb begin
        any_val = 1'b0;
        grant   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
            if (!any_val && cache_req_val[cand[IDX_W-1:0]]) begin
                any_val = 1'b1;
                grant   = cand[IDX_W-1:0];
            end
        end
    end

    // Handshakes are valid/ready: a transfer happens in a cycle where both are high;
    // valid never depends on ready. Reset gates the request side so it drops asynchronously.
    assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty      = (count_q == '0);
    assign memreq_val = reset & any_val & ~full;
    assign memreq_msg = cache_req_msg[int'(grant)*REQ_W +: REQ_W];
    assign req_fire   = memreq_val & memreq_rdy;

    assign head           = tag_q[rd_ptr_q];
    assign memresp_rdy    = ~empty & cache_resp_rdy[head];
    assign resp_fire      = memresp_val & memresp_rdy;
    assign cache_resp_msg = {NUM_PORTS{memresp_msg}};

    always_comb begin
        cache_req_rdy  = '0;
        cache_resp_val = '0;
        if (memreq_val) cache_req_rdy[grant] = memreq_rdy;
        if (!empty) cache_resp_val[head] = memresp_val;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req_fire) begin
            if (int'(grant) == NUM_PORTS - 1) rr_ptr_d = '0;
            else rr_ptr_d = grant + IDX_W'(1);
        end
        count_d = count_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            if (req_fire) begin
                tag_q[wr_ptr_q] <= grant;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (resp_fire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Completions arriving in the flush-start cycle count toward the new flush.
    always_comb begin
        fl_d       = fl_q;
        sticky_d   = sticky_q;
        flush_done = 1'b0;
        seen       = sticky_q | cache_flush_done;
        case (fl_q)
            FL_IDLE: begin
                if (flush) begin
                    sticky_d = cache_flush_done;
                    fl_d     = FL_WAIT;
                end
            end
            FL_WAIT: begin
                sticky_d = seen;
                if (&seen) fl_d = FL_DONE;
            end
            FL_DONE: begin
                flush_done = 1'b1;
                fl_d       = FL_IDLE;
            end
            default: fl_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fl_q     <= FL_IDLE;
            sticky_q <= '0;
        end else begin
            fl_q     <= fl_d;
            sticky_q <= sticky_d;
        end
    end

    assign flush_state_o = fl_q;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter with four channels and a four-deep tag FIFO.
module tb_cache_refill_arbiter;
    localparam int NP = 4;
    localparam int MO = 4;
    localparam int RW = 77;
    localparam int SW = 47;

    localparam int         RR_G  [6] = '{0, 1, 2, 3, 0, 1};
    localparam logic [3:0] RR_RV [6] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    localparam int         BP_G  [4] = '{2, 3, 0, 1};
    localparam logic [3:0] DR_RV [4] = '{4'h8, 4'h1, 4'h2, 4'h4};
    localparam logic       F1_FL [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    localparam logic [3:0] F1_CD [8] = '{4'h0, 4'h8, 4'h1, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0};
    localparam logic       F1_DN [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    localparam logic [1:0] F1_ST [8] = '{0, 1, 1, 1, 1, 1, 2, 0};
    localparam logic       F2_FL [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    localparam logic [3:0] F2_CD [8] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h2, 4'h8, 4'h0, 4'h0};
    localparam logic       F2_DN [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    localparam logic [1:0] F2_ST [8] = '{0, 0, 1, 1, 1, 1, 2, 0};

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    cache_req_val, cache_req_rdy, cache_resp_val, cache_resp_rdy, cache_flush_done;
    logic [NP*RW-1:0] cache_req_msg;
    logic [NP*SW-1:0] cache_resp_msg;
    logic             memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [RW-1:0]    memreq_msg;
    logic [SW-1:0]    memresp_msg;
    logic             flush, flush_done;
    logic [1:0]       flush_state;

    int n_cmp = 0;
    int n_err = 0;

    cache_refill_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MO), .REQ_W(RW), .RESP_W(SW)) dut (
        .clk(clk), .reset(reset),
        .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy), .cache_req_msg(cache_req_msg),
        .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy), .cache_resp_msg(cache_resp_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .flush(flush), .cache_flush_done(cache_flush_done), .flush_done(flush_done),
        .flush_state_o(flush_state)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] msg_of(input int i);
        logic [31:0] addr;
        addr = 32'(i) << 12;
        return {13'(i + 1), addr, 32'hD00D_0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input int g);
        logic [NP-1:0] onehot;
        onehot    = '0;
        onehot[g] = 1'b1;
        chk({tag, "_val"}, memreq_val, 1);
        chk({tag, "_msg"}, memreq_msg, msg_of(g));
        chk({tag, "_rdy"}, cache_req_rdy, onehot);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_memreq_val"}, memreq_val, 0);
        chk({tag, "_req_rdy"}, cache_req_rdy, 0);
        chk({tag, "_resp_val"}, cache_resp_val, 0);
        chk({tag, "_memresp_rdy"}, memresp_rdy, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
    endtask

    initial begin
        reset            = 1'b0;
        for (int i = 0; i < NP; i++) cache_req_msg[i*RW +: RW] = msg_of(i);
        cache_req_val    = '1;
        memreq_rdy       = 1'b1;
        memresp_val      = 1'b1;
        memresp_msg      = '0;
        cache_resp_rdy   = '1;
        flush            = 1'b0;
        cache_flush_done = '0;
        #2;
        chk_all_low("rst");
        chk("rst_flush_state", flush_state, 0);
        cache_req_val = '0;
        memresp_val   = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Round-robin with memory answering every cycle.
        cache_req_val = '1;
        memresp_val   = 1'b1;
        memresp_msg   = 47'h1_2345_6789;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk_grant($sformatf("rr%0d", k), RR_G[k]);
            chk($sformatf("rr%0d_resp_val", k), cache_resp_val, RR_RV[k]);
            tick();
        end
        cache_req_val = '0;
        #1;
        chk("rr_tail_resp_val", cache_resp_val, 4'h2);
        chk("rr_tail_memreq_val", memreq_val, 0);
        tick();
        memresp_val = 1'b0;
        #1;
        chk("rr_empty_memresp_rdy", memresp_rdy, 0);

        // Single channel refill.
        cache_req_val = 4'b0010;
        #1;
        chk_grant("single", 1);
        tick();
        cache_req_val = '0;
        memresp_val   = 1'b1;
        memresp_msg   = 47'hCAFE0001;
        #1;
        chk("single_resp_val", cache_resp_val, 4'b0010);
        chk("single_memresp_rdy", memresp_rdy, 1);
        chk("single_resp_msg", cache_resp_msg, {NP{47'hCAFE0001}});
        tick();
        chk("single_empty_rdy", memresp_rdy, 0);
        chk("single_empty_val", cache_resp_val, 0);
        memresp_val = 1'b0;

        // Backpressure: FIFO fills at four tags.
        cache_req_val = '1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_grant($sformatf("bp%0d", k), BP_G[k]);
            tick();
        end
        chk("bp_full_val", memreq_val, 0);
        chk("bp_full_rdy", cache_req_rdy, 0);
        tick();
        chk("bp_full2_val", memreq_val, 0);
        memresp_val = 1'b1;
        #1;
        chk("bp_pop_resp_val", cache_resp_val, 4'b0100);
        chk("bp_pop_memreq_val", memreq_val, 0);
        tick();
        memresp_val = 1'b0;
        #1;
        chk_grant("bp_reopen", 2);
        tick();
        chk("bp_refull_val", memreq_val, 0);
        cache_req_val = '0;
        memresp_val   = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_val", k), cache_resp_val, DR_RV[k]);
            chk($sformatf("drain%0d_rdy", k), memresp_rdy, 1);
            tick();
        end
        chk("drain_empty_rdy", memresp_rdy, 0);
        memresp_val = 1'b0;

        // Head channel not ready blocks later responses.
        cache_req_val = 4'b0100;
        #1;
        chk_grant("ooo_t2", 2);
        tick();
        cache_req_val = 4'b0001;
        #1;
        chk_grant("ooo_t0", 0);
        tick();
        cache_req_val  = '0;
        memresp_val    = 1'b1;
        memresp_msg    = 47'h0AAA;
        cache_resp_rdy = 4'b1011;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ooo_stall%0d_rdy", k), memresp_rdy, 0);
            chk($sformatf("ooo_stall%0d_val", k), cache_resp_val, 4'b0100);
            tick();
        end
        cache_resp_rdy = '1;
        #1;
        chk("ooo_h2_val", cache_resp_val, 4'b0100);
        chk("ooo_h2_rdy", memresp_rdy, 1);
        tick();
        memresp_msg = 47'h0BBB;
        #1;
        chk("ooo_h0_val", cache_resp_val, 4'b0001);
        chk("ooo_h0_rdy", memresp_rdy, 1);
        tick();
        memresp_val = 1'b0;

        // Flush with staggered completions and an ignored second pulse.
        for (int k = 0; k < 8; k++) begin
            flush            = F1_FL[k];
            cache_flush_done = F1_CD[k];
            #1;
            chk($sformatf("fl1_c%0d_done", k), flush_done, F1_DN[k]);
            chk($sformatf("fl1_c%0d_state", k), flush_state, F1_ST[k]);
            tick();
        end
        // Idle pulses ignored, sticky cleared, start-cycle completions captured.
        for (int k = 0; k < 8; k++) begin
            flush            = F2_FL[k];
            cache_flush_done = F2_CD[k];
            #1;
            chk($sformatf("fl2_c%0d_done", k), flush_done, F2_DN[k]);
            chk($sformatf("fl2_c%0d_state", k), flush_state, F2_ST[k]);
            tick();
        end
        flush            = 1'b0;
        cache_flush_done = '0;

        // Asynchronous reset with three tags in flight.
        cache_req_val = '1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_grant($sformatf("ar%0d", k), k + 1);
            tick();
        end
        memresp_val = 1'b1;
        #1;
        chk("ar_pre_resp_val", cache_resp_val, 4'b0010);
        chk("ar_pre_memreq_val", memreq_val, 1);
        reset = 1'b0;
        #1;
        chk_all_low("ar_mid");
        #1;
        reset = 1'b1;
        #1;
        chk_grant("ar_post", 0);
        chk("ar_post_memresp_rdy", memresp_rdy, 0);
        chk("ar_post_resp_val", cache_resp_val, 0);
        tick();
        cache_req_val = '0;
        memresp_val   = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
